// File: rtl/bus_dma_master.sv
// -----------------------------------------------------------------------------
// bus_dma_master
//
// Single-channel bus master that copies a block of words from one bus address
// range to another. It drives the slave fabric (address decoder, SRAM, timer)
// directly: it presents the address, write data and the active-low write strobe,
// and it takes the muxed read data back from the slaves.
//
// Reads rely on the slaves' synchronous read. The read address is held for
// READ_LAT+1 cycles, so the slave select stays valid while the data is captured.
//
// Build option:
//   DMA_FILL_EN  Adds i_fill and i_pattern. With i_fill=1 the source is not
//                read, and every destination word gets i_pattern at one word
//                per cycle. When the macro is undefined, only copy is built.
//
// Ports:
//   i_clk        clock, rising edge
//   i_reset      asynchronous reset, active high
//   i_start      request, sampled only in IDLE
//   i_src        source start address, captured on accepted start
//   i_dst        destination start address, captured on accepted start
//   i_len        word count, captured on accepted start
//   i_abort      stop the transfer early
//   i_fill       (DMA_FILL_EN) pattern fill instead of copy
//   i_pattern    (DMA_FILL_EN) fill data
//   i_bus_rdata  muxed slave read data
//   o_busy       high from the cycle after an accepted start until back in IDLE
//   o_done       1-cycle pulse, transfer completed
//   o_aborted    1-cycle pulse, transfer ended by abort
//   o_bus_addr   bus address
//   o_bus_wdata  bus write data
//   o_bus_rw_    1 = read, 0 = write
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start, bus parked at address 0 in read mode
// RD    | source address on the bus for READ_LAT+1 cycles, data captured
// WR    | one write cycle to the destination, pointers advance
// FIN   | one cycle, then the done/aborted pulse together with return to IDLE
// -----------------------------------------------------------------------------
module bus_dma_master #(
    parameter int BUS_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH     = 16,
    parameter int LEN_WIDTH      = 8,
    parameter int READ_LAT       = 1
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [BUS_ADDR_WIDTH-1:0] i_src,
    input  logic [BUS_ADDR_WIDTH-1:0] i_dst,
    input  logic [LEN_WIDTH-1:0]      i_len,
    input  logic                      i_abort,
`ifdef DMA_FILL_EN
    input  logic                      i_fill,
    input  logic [DATA_WIDTH-1:0]     i_pattern,
`endif
    input  logic [DATA_WIDTH-1:0]     i_bus_rdata,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_aborted,
    output logic [BUS_ADDR_WIDTH-1:0] o_bus_addr,
    output logic [DATA_WIDTH-1:0]     o_bus_wdata,
    output logic                      o_bus_rw_
);

    localparam int WAIT_W = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic [BUS_ADDR_WIDTH-1:0] r_src_ptr, w_src_nxt;
    logic [BUS_ADDR_WIDTH-1:0] r_dst_ptr, w_dst_nxt;
    logic [LEN_WIDTH-1:0]      r_count, w_count_nxt;
    logic [DATA_WIDTH-1:0]     r_buf, w_buf_nxt;
    logic [WAIT_W-1:0]         r_wait, w_wait_nxt;
    logic                      r_abt, w_abt_nxt;

    logic                      r_busy, w_busy_nxt;
    logic                      r_done, w_done_nxt;
    logic                      r_aborted, w_aborted_nxt;
    logic [BUS_ADDR_WIDTH-1:0] r_bus_addr, w_addr_nxt;
    logic [DATA_WIDTH-1:0]     r_bus_wdata, w_wdata_nxt;
    logic                      r_bus_rw_, w_rw_nxt;

    // Fill mode selection. In IDLE the values come straight from the inputs so
    // that the first fill write already carries the pattern being captured.
    logic                      w_fill_sel;
    logic [DATA_WIDTH-1:0]     w_pattern_sel;

`ifdef DMA_FILL_EN
    logic                      r_fill;
    logic [DATA_WIDTH-1:0]     r_pattern;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_fill    <= 1'b0;
            r_pattern <= '0;
        end else if (r_state == S_IDLE && i_start) begin
            r_fill    <= i_fill;
            r_pattern <= i_pattern;
        end
    end

    assign w_fill_sel    = (r_state == S_IDLE) ? i_fill    : r_fill;
    assign w_pattern_sel = (r_state == S_IDLE) ? i_pattern : r_pattern;
`else
    assign w_fill_sel    = 1'b0;
    assign w_pattern_sel = '0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_count     <= '0;
            r_buf       <= '0;
            r_wait      <= '0;
            r_abt       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_rw_   <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_src_ptr   <= w_src_nxt;
            r_dst_ptr   <= w_dst_nxt;
            r_count     <= w_count_nxt;
            r_buf       <= w_buf_nxt;
            r_wait      <= w_wait_nxt;
            r_abt       <= w_abt_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_aborted   <= w_aborted_nxt;
            r_bus_addr  <= w_addr_nxt;
            r_bus_wdata <= w_wdata_nxt;
            r_bus_rw_   <= w_rw_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_src_nxt     = r_src_ptr;
        w_dst_nxt     = r_dst_ptr;
        w_count_nxt   = r_count;
        w_buf_nxt     = r_buf;
        w_wait_nxt    = r_wait;
        w_abt_nxt     = r_abt;
        w_done_nxt    = 1'b0;
        w_aborted_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                // A concurrent abort is ignored here: the start is taken.
                if (i_start) begin
                    w_src_nxt   = i_src;
                    w_dst_nxt   = i_dst;
                    w_count_nxt = i_len;
                    w_abt_nxt   = 1'b0;
                    w_wait_nxt  = WAIT_W'(READ_LAT);
                    if (i_len == '0) begin
                        w_state_nxt = S_FIN;
                    end else if (w_fill_sel) begin
                        w_state_nxt = S_WR;
                    end else begin
                        w_state_nxt = S_RD;
                    end
                end
            end
            S_RD: begin
                if (i_abort) begin
                    // The pending read is dropped and no write is issued.
                    w_state_nxt = S_FIN;
                    w_abt_nxt   = 1'b1;
                end else if (r_wait == '0) begin
                    w_buf_nxt   = i_bus_rdata;
                    w_state_nxt = S_WR;
                end else begin
                    w_wait_nxt = r_wait - WAIT_W'(1);
                end
            end
            S_WR: begin
                // The write on the bus this cycle always completes.
                w_src_nxt   = r_src_ptr + BUS_ADDR_WIDTH'(1);
                w_dst_nxt   = r_dst_ptr + BUS_ADDR_WIDTH'(1);
                w_count_nxt = r_count - LEN_WIDTH'(1);
                w_wait_nxt  = WAIT_W'(READ_LAT);
                if (i_abort) begin
                    w_state_nxt = S_FIN;
                    w_abt_nxt   = 1'b1;
                end else if (r_count == LEN_WIDTH'(1)) begin
                    w_state_nxt = S_FIN;
                end else if (w_fill_sel) begin
                    w_state_nxt = S_WR;
                end else begin
                    w_state_nxt = S_RD;
                end
            end
            S_FIN: begin
                w_state_nxt   = S_IDLE;
                w_done_nxt    = ~r_abt;
                w_aborted_nxt = r_abt;
                w_abt_nxt     = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // The bus outputs are registered, so they are derived from the state
        // being entered. This keeps them aligned with the state cycle.
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_addr_nxt  = '0;
        w_rw_nxt    = 1'b1;
        w_wdata_nxt = r_bus_wdata;
        case (w_state_nxt)
            S_RD: begin
                w_addr_nxt = w_src_nxt;
            end
            S_WR: begin
                w_addr_nxt  = w_dst_nxt;
                w_rw_nxt    = 1'b0;
                w_wdata_nxt = w_fill_sel ? w_pattern_sel : w_buf_nxt;
            end
            default: begin
                w_addr_nxt = '0;
            end
        endcase
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_aborted   = r_aborted;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_wdata = r_bus_wdata;
    assign o_bus_rw_   = r_bus_rw_;

endmodule

// File: tb/tb_bus_dma_master.sv
module tb_bus_dma_master;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] len;
    logic          abort;
    logic          fill;
    logic [DW-1:0] pattern;
    logic [DW-1:0] rdata;
    logic          busy, done, aborted, rw_;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;

    int n_cmp = 0;
    int n_err = 0;
    int n_wr, n_done, n_abt;
    logic [AW-1:0] wr_addr [$];

    logic [DW-1:0] mem [0:1023];
    logic          tb_we = 1'b0;
    logic [AW-1:0] tb_waddr = '0;
    logic [DW-1:0] tb_wdata = '0;

    always #5 clk = ~clk;

    bus_dma_master dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_src       (src),
        .i_dst       (dst),
        .i_len       (len),
        .i_abort     (abort),
`ifdef DMA_FILL_EN
        .i_fill      (fill),
        .i_pattern   (pattern),
`endif
        .i_bus_rdata (rdata),
        .o_busy      (busy),
        .o_done      (done),
        .o_aborted   (aborted),
        .o_bus_addr  (addr),
        .o_bus_wdata (wdata),
        .o_bus_rw_   (rw_)
    );

    // SRAM slave with a one-cycle synchronous read, plus a bench preload port.
    always @(posedge clk) begin
        if (tb_we) mem[tb_waddr] <= tb_wdata;
        else if (!rw_) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (!rw_) begin
                n_wr++;
                wr_addr.push_back(addr);
            end
            if (done) n_done++;
            if (aborted) n_abt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        tb_we = 1'b1;
        tb_waddr = a;
        tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic start_dma(input logic [AW-1:0] s, input logic [AW-1:0] d,
                             input logic [LW-1:0] l, input logic f,
                             input logic [DW-1:0] p, input logic abt_with_start);
        @(negedge clk);
        n_wr = 0;
        n_done = 0;
        n_abt = 0;
        wr_addr.delete();
        src = s;
        dst = d;
        len = l;
        fill = f;
        pattern = p;
        abort = abt_with_start;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Returns the cycle index (start cycle = 0) at which done or aborted is seen.
    task automatic wait_end(input logic abort_3rd_rd, output int lat);
        bit sent;
        sent = 0;
        lat = -1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            abort = 1'b0;
            if (done || aborted) begin
                lat = k;
                break;
            end
            if (abort_3rd_rd && !sent && n_wr == 2 && rw_ && busy) begin
                abort = 1'b1;
                sent = 1;
            end
        end
        abort = 1'b0;
    endtask

    int lat;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        src = '0;
        dst = '0;
        len = '0;
        abort = 1'b0;
        fill = 1'b0;
        pattern = '0;
        n_wr = 0;
        n_done = 0;
        n_abt = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_rw", rw_, 1);
        rst = 1'b0;

        // Copy of four words.
        preload(10'h000, 16'h1111);
        preload(10'h001, 16'h2222);
        preload(10'h002, 16'h3333);
        preload(10'h003, 16'h4444);
        start_dma(10'h000, 10'h100, 8'd4, 1'b0, 16'h0, 1'b0);
        wait_end(1'b0, lat);
        chk("copy_lat", lat, 14);
        chk("copy_busy_end", busy, 0);
        chk("copy_rw_end", rw_, 1);
        repeat (3) @(negedge clk);
        chk("copy_m100", mem[10'h100], 16'h1111);
        chk("copy_m101", mem[10'h101], 16'h2222);
        chk("copy_m102", mem[10'h102], 16'h3333);
        chk("copy_m103", mem[10'h103], 16'h4444);
        chk("copy_nwr", n_wr, 4);
        chk("copy_wa0", wr_addr[0], 10'h100);
        chk("copy_wa3", wr_addr[3], 10'h103);
        chk("copy_ndone", n_done, 1);
        chk("copy_nabt", n_abt, 0);

        // Zero length, abort together with start is ignored.
        start_dma(10'h000, 10'h140, 8'd0, 1'b0, 16'h0, 1'b1);
        wait_end(1'b0, lat);
        chk("len0_lat", lat, 2);
        chk("len0_done", done, 1);
        repeat (3) @(negedge clk);
        chk("len0_nwr", n_wr, 0);
        chk("len0_nabt", n_abt, 0);

        // Source pointer wrap.
        preload(10'h3FE, 16'hBEEF);
        preload(10'h3FF, 16'hCAFE);
        start_dma(10'h3FE, 10'h010, 8'd3, 1'b0, 16'h0, 1'b0);
        wait_end(1'b0, lat);
        chk("wrap_lat", lat, 11);
        repeat (3) @(negedge clk);
        chk("wrap_m010", mem[10'h010], 16'hBEEF);
        chk("wrap_m011", mem[10'h011], 16'hCAFE);
        chk("wrap_m012", mem[10'h012], 16'h1111);
        chk("wrap_wa2", wr_addr[2], 10'h012);

        // Abort during the third read.
        preload(10'h200, 16'hA001);
        preload(10'h201, 16'hA002);
        preload(10'h202, 16'hA003);
        preload(10'h302, 16'hDEAD);
        start_dma(10'h200, 10'h300, 8'd8, 1'b0, 16'h0, 1'b0);
        wait_end(1'b1, lat);
        chk("abt_lat", lat, 9);
        chk("abt_pulse", aborted, 1);
        chk("abt_busy", busy, 0);
        repeat (4) @(negedge clk);
        chk("abt_nwr", n_wr, 2);
        chk("abt_ndone", n_done, 0);
        chk("abt_nabt", n_abt, 1);
        chk("abt_m300", mem[10'h300], 16'hA001);
        chk("abt_m301", mem[10'h301], 16'hA002);
        chk("abt_m302", mem[10'h302], 16'hDEAD);

        // Reset in the middle of a read.
        start_dma(10'h000, 10'h180, 8'd4, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        chk("mid_rd_busy", busy, 1);
        chk("mid_rd_addr", addr, 10'h000);
        #2 rst = 1'b1;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_rw", rw_, 1);
        chk("mrst_done", done, 0);
        chk("mrst_aborted", aborted, 0);
        chk("mrst_addr", addr, 0);
        chk("mrst_wdata", wdata, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("mrst_ndone", n_done, 0);
        chk("mrst_nwr", n_wr, 0);
        chk("mrst_m180", mem[10'h180], 16'h0000);

`ifdef DMA_FILL_EN
        start_dma(10'h000, 10'h120, 8'd5, 1'b1, 16'hA5A5, 1'b0);
        wait_end(1'b0, lat);
        chk("fill_lat", lat, 7);
        repeat (3) @(negedge clk);
        chk("fill_m120", mem[10'h120], 16'hA5A5);
        chk("fill_m124", mem[10'h124], 16'hA5A5);
        chk("fill_m125", mem[10'h125], 16'h0000);
        chk("fill_nwr", n_wr, 5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
